model_input_loader: RTL

Upstream feeder for `model`. It accepts scalar words on a valid/ready stream and assembles `IN_DIM` words into the parallel vector that drives `model.in_data`. It then issues a one-cycle `vec_valid` (to `model.in_valid`) and holds the vector stable until `model_done` (from `model.out_ready`) returns. It also enforces framing with `s_last`, discarding malformed vectors and resynchronising to the next frame boundary.

---
 rtl/model_input_loader.sv | 114 +++++++++++
 1 files changed

// File: rtl/model_input_loader.sv
// Stream-to-vector loader feeding the model: gathers IN_DIM words framed by s_last,
// issues a one-cycle vec_valid and holds the vector until model_done returns.
module model_input_loader #(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned IN_DIM = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IN_W-1:0]   s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [IN_W-1:0]   vec_data [0:IN_DIM-1],
    output logic              vec_valid,
    input  logic              model_done,
    output logic              busy,
    output logic              frame_err,
    output logic [CNT_W-1:0]  vec_count
);

    localparam int unsigned IDX_W = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_DIM - 1);

    typedef enum logic [1:0] {StFill, StIssue, StWait, StDrain} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              frame_err_q, frame_err_d;
    logic              wr_en;
    logic              xfer;
    logic [IN_W-1:0]   vec_q [0:IN_DIM-1];

    assign s_ready = (state_q == StFill) || (state_q == StDrain);
    assign xfer    = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        frame_err_d = 1'b0;
        wr_en       = 1'b0;
        unique case (state_q)
            StFill: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (s_last) begin
                            state_d = StIssue;
                            // Counted on entry so vec_count is current while vec_valid is high
                            cnt_d   = cnt_q + CNT_W'(1);
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = StDrain;
                        end
                    end else if (s_last) begin
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            StIssue: begin
                state_d = model_done ? StFill : StWait;
            end
            StWait: begin
                if (model_done) begin
                    state_d = StFill;
                end
            end
            StDrain: begin
                if (xfer && s_last) begin
                    state_d = StFill;
                    idx_d   = '0;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StFill;
            idx_q       <= '0;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(IN_DIM); i++) begin
                vec_q[i] <= '0;
            end
        end else if (wr_en) begin
            vec_q[idx_q] <= s_data;
        end
    end

    assign vec_data  = vec_q;
    assign vec_valid = (state_q == StIssue);
    assign busy      = (state_q == StIssue) || (state_q == StWait);
    assign frame_err = frame_err_q;
    assign vec_count = cnt_q;

endmodule
